// File: rtl/edge_binarise_if.sv
// Pixel/Frame/Line stream in and out of the edge binariser, plus its static frame controls.
interface edge_binarise_if #(
  parameter int unsigned PIX_W = 8
);
  logic [PIX_W-1:0] PixelIn;
  logic             FrameIn;
  logic             LineIn;
  logic [7:0]       Width;
  logic [8:0]       Threshold;
  logic [PIX_W-1:0] PixelOut;
  logic             FrameOut;
  logic             LineOut;

  modport master (
    output PixelIn, FrameIn, LineIn, Width, Threshold,
    input  PixelOut, FrameOut, LineOut
  );

  modport slave (
    input  PixelIn, FrameIn, LineIn, Width, Threshold,
    output PixelOut, FrameOut, LineOut
  );
endinterface

// File: rtl/edge_binarise.sv
// Greyscale stream to binary edge map using |dI/dx| + |dI/dy| against a threshold.
// Two-register pipeline; a single line buffer supplies the pixel above.
module edge_binarise #(
  parameter int unsigned MAX_WIDTH = 256,
  parameter int unsigned PIX_W     = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  edge_binarise_if.slave  bus_io
);

  localparam int unsigned XW = $clog2(MAX_WIDTH);
  localparam int unsigned CW = ((XW > 8) ? XW : 8) + 1;
  localparam int unsigned SW = PIX_W + 1;
  localparam int unsigned TW = (SW > 9) ? SW : 9;

  logic [PIX_W-1:0] line_mem [MAX_WIDTH];

  logic [XW-1:0]    x_q, x_d;
  logic             first_line_q, first_line_d;
  logic             pos_valid_q, pos_valid_d;
  logic             left_valid_q;
  logic [PIX_W-1:0] left_q;

  logic [SW-1:0]    sum_q, sum_d;
  logic             inactive_q, inactive_d;
  logic             frame1_q, line1_q;

  logic [PIX_W-1:0] pix_q, pix_d;
  logic             frame2_q, line2_q;

  logic [PIX_W-1:0] up_c;
  logic [PIX_W-1:0] dx_c, dy_c;
  logic [CW-1:0]    width_c;
  logic             wr_en_c;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a > b) ? PIX_W'(a - b) : PIX_W'(b - a);
  endfunction

  // Width of 0 encodes a full 256-pixel line, the only value 8 bits cannot hold.
  assign width_c = (bus_io.Width == 8'd0) ? CW'(256) : CW'(bus_io.Width);

  // Position tracking, gradient and stage-2 decision.
  always_comb begin
    x_d          = (x_q == XW'(MAX_WIDTH - 1)) ? x_q : XW'(x_q + XW'(1));
    first_line_d = first_line_q;
    pos_valid_d  = pos_valid_q;
    if (bus_io.FrameIn) begin
      x_d          = '0;
      first_line_d = 1'b1;
      pos_valid_d  = 1'b1;
    end else if (bus_io.LineIn) begin
      x_d          = '0;
      first_line_d = 1'b0;
      pos_valid_d  = 1'b1;
    end

    up_c       = line_mem[x_d];
    dx_c       = ((x_d == '0) || !left_valid_q) ? '0 : abs_diff(bus_io.PixelIn, left_q);
    dy_c       = first_line_d ? '0 : abs_diff(bus_io.PixelIn, up_c);
    sum_d      = SW'(dx_c) + SW'(dy_c);
    wr_en_c    = (CW'(x_d) < width_c);
    inactive_d = !pos_valid_d || !wr_en_c;

    pix_d = (!inactive_q && (TW'(sum_q) >= TW'(bus_io.Threshold))) ? '1 : '0;
  end

  // Read-before-write: the comb read above sees the previous line's value this cycle.
  always_ff @(posedge Clk) begin
    if (wr_en_c) line_mem[x_d] <= bus_io.PixelIn;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x_q          <= '0;
      first_line_q <= 1'b1;
      pos_valid_q  <= 1'b0;
      left_valid_q <= 1'b0;
      left_q       <= '0;
      sum_q        <= '0;
      inactive_q   <= 1'b1;
      frame1_q     <= 1'b0;
      line1_q      <= 1'b0;
      pix_q        <= '0;
      frame2_q     <= 1'b0;
      line2_q      <= 1'b0;
    end else begin
      x_q          <= x_d;
      first_line_q <= first_line_d;
      pos_valid_q  <= pos_valid_d;
      left_valid_q <= 1'b1;
      left_q       <= bus_io.PixelIn;
      sum_q        <= sum_d;
      inactive_q   <= inactive_d;
      frame1_q     <= bus_io.FrameIn;
      line1_q      <= bus_io.LineIn;
      pix_q        <= pix_d;
      frame2_q     <= frame1_q;
      line2_q      <= line1_q;
    end
  end

  assign bus_io.PixelOut = pix_q;
  assign bus_io.FrameOut = frame2_q;
  assign bus_io.LineOut  = line2_q;

endmodule
